// File: rtl/dmac_ctrl_regs_if.sv
// AXI4-Lite control-port bundle for the DMA controller register block.
// The master modport is the host side, the slave modport is the register block.
`timescale 1ns/1ps
interface dmac_ctrl_regs_if #(
  parameter int ADDR_WIDTH = 12
) ();
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  rvalid;
  logic                  rready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/dmac_ctrl_regs.sv
// AXI4-Lite control/status registers for the DMA engine: start pulse, length,
// source/destination addresses and a sticky completion flag polled by the host.
`timescale 1ns/1ps
module dmac_ctrl_regs #(
  parameter int C_S_AXI_CONTROL_ADDR_WIDTH = 12,
  parameter int C_S_AXI_CONTROL_DATA_WIDTH = 32
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  dmac_ctrl_regs_if.slave        s_axi_control,
  output logic                   o_start,
  output logic [31:0]            o_byte_len,
  output logic [31:0]            o_src_addr,
  output logic [31:0]            o_dst_addr,
  input  logic                   i_done
);

  if (C_S_AXI_CONTROL_DATA_WIDTH != 32) begin : g_bad_width
    $error("dmac_ctrl_regs supports only a 32-bit control data width");
  end

  localparam logic [5:0] ADDR_CTRL = 6'h10;
  localparam logic [5:0] ADDR_LEN  = 6'h14;
  localparam logic [5:0] ADDR_SRC  = 6'h18;
  localparam logic [5:0] ADDR_DST  = 6'h1C;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  w_state_e    w_state_q, w_state_d;
  r_state_e    r_state_q, r_state_d;

  logic [5:0]  waddr_q;
  logic [31:0] byte_len_q, src_q, dst_q;
  logic        ap_start_q, ap_done_q, ap_idle_q, ap_ready_q;
  logic        start_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] wmask;

  logic aw_hs, w_hs, ar_hs;
  logic start_fire, cfg_we;

  assign aw_hs = s_axi_control.awvalid && s_axi_control.awready;
  assign w_hs  = s_axi_control.wvalid  && s_axi_control.wready;
  assign ar_hs = s_axi_control.arvalid && s_axi_control.arready;

  // Upper address bits are not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_control.awaddr[C_S_AXI_CONTROL_ADDR_WIDTH-1:6],
                              s_axi_control.araddr[C_S_AXI_CONTROL_ADDR_WIDTH-1:6]};

  // ---------------- write channel FSM ----------------
  always_ff @(posedge ap_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (ap_rst) w_state_q <= W_IDLE;
    else        w_state_q <= w_state_d;
  end

  always_comb begin
    // NOTE: default first so no path leaves the next state unassigned (no latch).
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (s_axi_control.awvalid) w_state_d = W_DATA;
      W_DATA:  if (s_axi_control.wvalid)  w_state_d = W_RESP;
      W_RESP:  if (s_axi_control.bready)  w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi_control.awready = (w_state_q == W_IDLE);
    s_axi_control.wready  = (w_state_q == W_DATA);
    s_axi_control.bvalid  = (w_state_q == W_RESP);
    s_axi_control.bresp   = 2'b00;
  end

  // ---------------- read channel FSM ----------------
  always_ff @(posedge ap_clk) begin
    if (ap_rst) r_state_q <= R_IDLE;
    else        r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (s_axi_control.arvalid) r_state_d = R_DATA;
      R_DATA:  if (s_axi_control.rready)  r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_control.arready = (r_state_q == R_IDLE);
    s_axi_control.rvalid  = (r_state_q == R_DATA);
    s_axi_control.rdata   = rdata_q;
    s_axi_control.rresp   = 2'b00;
  end

  // ---------------- register file ----------------
  always_comb begin
    for (int i = 0; i < 4; i++) wmask[8*i +: 8] = {8{s_axi_control.wstrb[i]}};
  end

  // Configuration is frozen while a transfer is in flight.
  assign cfg_we     = w_hs && !ap_start_q;
  assign start_fire = w_hs && (waddr_q == ADDR_CTRL) && !ap_start_q &&
                      s_axi_control.wdata[0] && s_axi_control.wstrb[0];

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      waddr_q <= '0;
    end else if (aw_hs) begin
      waddr_q <= s_axi_control.awaddr[5:0];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      byte_len_q <= '0;
      src_q      <= '0;
      dst_q      <= '0;
    end else if (cfg_we) begin
      case (waddr_q)
        ADDR_LEN: byte_len_q <= (byte_len_q & ~wmask) | (s_axi_control.wdata & wmask);
        ADDR_SRC: src_q      <= (src_q      & ~wmask) | (s_axi_control.wdata & wmask);
        ADDR_DST: dst_q      <= (dst_q      & ~wmask) | (s_axi_control.wdata & wmask);
        default:  ;
      endcase
    end
  end

  // Later assignments take priority: a completion pulse beats a same-cycle
  // status-read clear, so the host never loses a done event.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ap_start_q <= 1'b0;
      ap_done_q  <= 1'b0;
      ap_idle_q  <= 1'b1;
      ap_ready_q <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      start_q    <= start_fire;
      ap_ready_q <= start_fire;
      if (start_fire) begin
        ap_start_q <= 1'b1;
        ap_idle_q  <= 1'b0;
      end
      if (ar_hs && (s_axi_control.araddr[5:0] == ADDR_CTRL)) ap_done_q <= 1'b0;
      if (i_done) begin
        ap_done_q  <= 1'b1;
        ap_start_q <= 1'b0;
        ap_idle_q  <= 1'b1;
      end
    end
  end

  // ---------------- read data ----------------
  always_comb begin
    rdata_d = '0;
    case (s_axi_control.araddr[5:0])
      ADDR_CTRL: rdata_d = {28'd0, ap_ready_q, ap_idle_q, ap_done_q, ap_start_q};
      ADDR_LEN:  rdata_d = byte_len_q;
      ADDR_SRC:  rdata_d = src_q;
      ADDR_DST:  rdata_d = dst_q;
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst)     rdata_q <= '0;
    else if (ar_hs) rdata_q <= rdata_d;
  end

  assign o_start    = start_q;
  assign o_byte_len = byte_len_q;
  assign o_src_addr = src_q;
  assign o_dst_addr = dst_q;

endmodule

// File: tb/tb_dmac_ctrl_regs.sv
// Scoreboard bench for dmac_ctrl_regs: drivers push expected responses from a
// register-map model, monitors pop and compare on each B/R handshake.
`timescale 1ns/1ps
module tb_dmac_ctrl_regs;

  localparam int TMO = 50;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        i_done = 1'b0;
  logic        o_start;
  logic [31:0] o_byte_len, o_src_addr, o_dst_addr;

  dmac_ctrl_regs_if #(.ADDR_WIDTH(12)) axi ();

  dmac_ctrl_regs #(
    .C_S_AXI_CONTROL_ADDR_WIDTH(12),
    .C_S_AXI_CONTROL_DATA_WIDTH(32)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .s_axi_control (axi),
    .o_start       (o_start),
    .o_byte_len    (o_byte_len),
    .o_src_addr    (o_src_addr),
    .o_dst_addr    (o_dst_addr),
    .i_done        (i_done)
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of the host-visible register map.
  logic [31:0] m_len, m_src, m_dst;
  logic        m_start, m_done, m_idle;
  int          exp_starts  = 0;
  int          seen_starts = 0;
  int          start_width = 0;

  logic [31:0] rq[$];
  logic [1:0]  bq[$];
  logic [31:0] exp_r;
  logic [1:0]  exp_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] off);
    case (off)
      6'h10:   return {29'd0, m_idle, m_done, m_start};
      6'h14:   return m_len;
      6'h18:   return m_src;
      6'h1C:   return m_dst;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_write(input logic [5:0] off, input logic [31:0] d, input logic [3:0] s);
    if (off == 6'h10) begin
      if (d[0] && s[0] && !m_start) begin
        m_start = 1'b1;
        m_idle  = 1'b0;
        exp_starts++;
      end
    end else if (!m_start) begin
      if (off == 6'h14) m_len = merge(m_len, d, s);
      if (off == 6'h18) m_src = merge(m_src, d, s);
      if (off == 6'h1C) m_dst = merge(m_dst, d, s);
    end
  endtask

  task automatic model_done();
    m_done  = 1'b1;
    m_start = 1'b0;
    m_idle  = 1'b1;
  endtask

  task automatic model_reset();
    m_len = '0; m_src = '0; m_dst = '0;
    m_start = 1'b0; m_done = 1'b0; m_idle = 1'b1;
    rq.delete();
    bq.delete();
  endtask

  // ---------------- monitors ----------------
  always @(negedge ap_clk) begin
    if (axi.rvalid && axi.rready) begin
      check("r_queue_nonempty", 32'(rq.size() > 0), 32'd1);
      if (rq.size() > 0) begin
        exp_r = rq.pop_front();
        check("rdata", axi.rdata, exp_r);
        check("rresp", 32'(axi.rresp), 32'd0);
      end
    end
    if (axi.bvalid && axi.bready) begin
      check("b_queue_nonempty", 32'(bq.size() > 0), 32'd1);
      if (bq.size() > 0) begin
        exp_b = bq.pop_front();
        check("bresp", 32'(axi.bresp), 32'(exp_b));
      end
    end
    if (o_start) start_width++;
    else if (start_width != 0) begin
      check("o_start_width", 32'(start_width), 32'd1);
      seen_starts++;
      start_width = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return axi.awready;
      1:       return axi.wready;
      2:       return axi.bvalid;
      3:       return axi.arready;
      4:       return axi.rvalid;
      default: return 1'b0;
    endcase
  endfunction

  // Returns at the negedge on which the selected signal is high.
  task automatic wait_sig(input int which, input string name, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    forever begin
      @(negedge ap_clk);
      if (sig(which)) return;
      n++;
      if (n >= TMO) begin
        n_checks++;
        $display("FAIL %s: no response after %0d cycles, required within %0d", name, n, TMO);
        ok = 1'b0;
        return;
      end
      step();
    end
  endtask

  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int max_dly,
                           output int aw_cyc, output int b_cyc);
    bit ok;
    aw_cyc = -1;
    b_cyc  = -1;
    axi.awvalid = 1'b1;
    axi.awaddr  = addr;
    wait_sig(0, "awready", ok);
    if (!ok) begin axi.awvalid = 1'b0; return; end
    aw_cyc = cyc;
    step();
    axi.awvalid = 1'b0;
    repeat ($urandom_range(max_dly, 0)) step();
    axi.wvalid = 1'b1;
    axi.wdata  = data;
    axi.wstrb  = strb;
    wait_sig(1, "wready", ok);
    if (!ok) begin axi.wvalid = 1'b0; return; end
    model_write(addr[5:0], data, strb);
    bq.push_back(2'b00);
    step();
    axi.wvalid = 1'b0;
    repeat ($urandom_range(max_dly, 0)) step();
    axi.bready = 1'b1;
    wait_sig(2, "bvalid", ok);
    b_cyc = cyc;
    step();
    axi.bready = 1'b0;
    check("o_byte_len", o_byte_len, m_len);
    check("o_src_addr", o_src_addr, m_src);
    check("o_dst_addr", o_dst_addr, m_dst);
  endtask

  task automatic axi_read(input logic [11:0] addr, input bit with_done, input int max_dly);
    bit ok;
    axi.arvalid = 1'b1;
    axi.araddr  = addr;
    wait_sig(3, "arready", ok);
    if (!ok) begin axi.arvalid = 1'b0; return; end
    rq.push_back(model_read(addr[5:0]));
    if (with_done) i_done = 1'b1;
    if (addr[5:0] == 6'h10) m_done = 1'b0;
    if (with_done) model_done();
    step();
    axi.arvalid = 1'b0;
    i_done      = 1'b0;
    repeat ($urandom_range(max_dly, 0)) step();
    axi.rready = 1'b1;
    wait_sig(4, "rvalid", ok);
    step();
    axi.rready = 1'b0;
  endtask

  task automatic pulse_done();
    i_done = 1'b1;
    @(negedge ap_clk);
    model_done();
    step();
    i_done = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] offs [7] = '{6'h10, 6'h14, 6'h18, 6'h1C, 6'h00, 6'h3C, 6'h24};

  initial begin
    int a_c, b_c, a_c2, b_c2;
    logic [5:0]  hi;
    logic [11:0] ad;
    int op;

    axi.awvalid = 1'b0; axi.awaddr = '0; axi.wvalid = 1'b0; axi.wdata = '0;
    axi.wstrb = '0; axi.bready = 1'b0; axi.arvalid = 1'b0; axi.araddr = '0;
    axi.rready = 1'b0;
    model_reset();

    repeat (3) step();
    ap_rst = 1'b0;
    check("rst_o_start", 32'(o_start), 32'd0);
    check("rst_o_byte_len", o_byte_len, 32'd0);
    check("rst_o_src_addr", o_src_addr, 32'd0);
    check("rst_o_dst_addr", o_dst_addr, 32'd0);
    check("rst_awready", 32'(axi.awready), 32'd1);
    check("rst_arready", 32'(axi.arready), 32'd1);
    check("rst_bvalid", 32'(axi.bvalid), 32'd0);
    check("rst_rvalid", 32'(axi.rvalid), 32'd0);

    // Reset values through the bus.
    axi_read(12'h010, 1'b0, 0);
    axi_read(12'h014, 1'b0, 0);
    axi_read(12'h018, 1'b0, 0);
    axi_read(12'h01C, 1'b0, 0);

    // Configuration writes with minimum-latency handshakes.
    axi_write(12'h014, 32'h0000_1000, 4'hF, 0, a_c, b_c);
    check("bvalid_latency_len", 32'(b_c - a_c), 32'd2);
    axi_write(12'h018, 32'h1000_0000, 4'hF, 0, a_c, b_c);
    check("bvalid_latency_src", 32'(b_c - a_c), 32'd2);
    axi_write(12'h01C, 32'h2000_0000, 4'hF, 0, a_c, b_c);
    check("bvalid_latency_dst", 32'(b_c - a_c), 32'd2);
    axi_read(12'h014, 1'b0, 0);
    axi_read(12'h018, 1'b0, 0);
    axi_read(12'h01C, 1'b0, 0);

    // Start, then a config write that must be ignored while busy.
    axi_write(12'h010, 32'h0000_0001, 4'hF, 0, a_c, b_c);
    step();
    check("start_count", 32'(seen_starts), 32'(exp_starts));
    axi_read(12'h010, 1'b0, 0);
    axi_write(12'h014, 32'h0000_0020, 4'hF, 0, a_c, b_c);
    check("len_frozen_busy", o_byte_len, 32'h0000_1000);
    axi_write(12'h010, 32'h0000_0001, 4'hF, 0, a_c, b_c);

    // Completion: sticky done, cleared by reading CTRL.
    pulse_done();
    axi_read(12'h010, 1'b0, 0);
    axi_read(12'h010, 1'b0, 0);

    // Completion coinciding with the CTRL read address handshake.
    axi_read(12'h010, 1'b1, 0);
    axi_read(12'h010, 1'b0, 0);
    axi_read(12'h010, 1'b0, 0);

    // Byte strobes, unmapped offsets.
    axi_write(12'h018, 32'hAAAA_BBBB, 4'b0011, 0, a_c, b_c);
    check("src_strobed", o_src_addr, 32'h1000_BBBB);
    axi_read(12'h03C, 1'b0, 0);
    axi_write(12'h03C, 32'hDEAD_BEEF, 4'hF, 0, a_c, b_c);
    axi_read(12'h03C, 1'b0, 0);

    // Independent read and write channels in flight together.
    fork
      axi_write(12'h01C, 32'h3333_4444, 4'hF, 0, a_c, b_c);
      axi_read(12'h014, 1'b0, 0);
    join
    check("dst_concurrent", o_dst_addr, 32'h3333_4444);

    // Reset while the write FSM waits for data.
    axi.awvalid = 1'b1;
    axi.awaddr  = 12'h014;
    wait_sig(0, "awready_pre_reset", a_c2[0]);
    step();
    axi.awvalid = 1'b0;
    ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
    model_reset();
    check("midrst_awready", 32'(axi.awready), 32'd1);
    check("midrst_wready", 32'(axi.wready), 32'd0);
    check("midrst_bvalid", 32'(axi.bvalid), 32'd0);
    check("midrst_o_byte_len", o_byte_len, 32'd0);
    axi_read(12'h010, 1'b0, 0);

    // Randomized traffic against the model.
    for (int it = 0; it < 120; it++) begin
      op = int'($urandom_range(0, 9));
      hi = 6'($urandom_range(0, 63));
      ad = {hi, offs[$urandom_range(0, 6)]};
      case (op)
        0, 1, 2, 3: axi_write(ad, $urandom, 4'($urandom_range(0, 15)), 3, a_c2, b_c2);
        4, 5, 6:    axi_read(ad, 1'b0, 3);
        7:          pulse_done();
        8:          axi_read({hi, 6'h10}, 1'b1, 3);
        default:    axi_write({hi, 6'h10}, 32'h1, 4'hF, 3, a_c2, b_c2);
      endcase
      repeat ($urandom_range(2, 0)) step();
    end
    axi_read(12'h010, 1'b0, 0);

    repeat (4) step();
    check("start_count_final", 32'(seen_starts), 32'(exp_starts));
    check("r_queue_drained", 32'(rq.size()), 32'd0);
    check("b_queue_drained", 32'(bq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmac_ctrl_regs.md
Name: dmac_ctrl_regs

Overview:
AXI4-Lite control-register slave for the DMA engine. It sits directly upstream of the DMA datapath inside DMAC_TOP. It decodes host writes into a start pulse plus byte-length, source and destination address registers. It reports engine completion back to the host through a status word that is polled over the same AXI4-Lite port.

Parameters:
C_S_AXI_CONTROL_ADDR_WIDTH, 12, control address width (bits [5:0] decoded)
C_S_AXI_CONTROL_DATA_WIDTH, 32, control data width (fixed 32; other values unsupported)

Ports:
ap_clk  in  1  single clock
ap_rst  in  1  synchronous active-high reset
s_axi_control_awvalid/awready  in/out  1  write-address handshake
s_axi_control_awaddr  in  ADDR_WIDTH  write address
s_axi_control_wvalid/wready  in/out  1  write-data handshake
s_axi_control_wdata  in  32  write data
s_axi_control_wstrb  in  4  byte enables
s_axi_control_bvalid/bready  out/in  1  write-response handshake
s_axi_control_bresp  out  2  always 2'b00
s_axi_control_arvalid/arready  in/out  1  read-address handshake
s_axi_control_araddr  in  ADDR_WIDTH  read address
s_axi_control_rvalid/rready  out/in  1  read-data handshake
s_axi_control_rdata  out  32  read data
s_axi_control_rresp  out  2  always 2'b00
o_start  out  1  one-cycle start pulse to engine
o_byte_len  out  32  transfer length in bytes
o_src_addr  out  32  source base address
o_dst_addr  out  32  destination base address
i_done  in  1  one-cycle completion pulse from engine

Behaviour:
- Reset (ap_rst=1 at posedge):
  - All outputs and registers 0, except idle=1.
  - Reset mid-transaction abandons it: valid/ready deassert, FSMs return to IDLE.
- Register map (awaddr/araddr[5:0]):
  - 0x10 CTRL: bit0 ap_start, bit1 ap_done, bit2 ap_idle, bit3 ap_ready; other bits read 0.
  - 0x14 BYTE_LEN.
  - 0x18 SRC.
  - 0x1C DST.
  - Other offsets: read 0; writes ignored but still answered with OKAY.
- Write FSM, states W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1, wready=0. On awvalid, latch awaddr and go to W_DATA.
  - W_DATA: wready=1. On wvalid, perform the register write in that cycle and go to W_RESP.
  - W_RESP: bvalid=1 and held until bready, then back to W_IDLE.
  - Minimum write = 3 cycles.
- Write rules:
  - Byte-wise wstrb masking applies to 0x14/0x18/0x1C.
  - BYTE_LEN/SRC/DST writes are ignored while busy (ap_start=1); the response is still OKAY.
  - CTRL write with wdata[0]=1 and wstrb[0]=1 while idle:
    - sets ap_start=1 and clears ap_idle;
    - asserts o_start for exactly the next cycle.
  - CTRL write while busy has no effect.
  - Writes to CTRL bits 1..3 are ignored.
- ap_ready mirrors the o_start pulse cycle (set with o_start, cleared the next cycle).
- Read FSM, states R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On arvalid, rdata is registered from the decoded address (value before any same-cycle update) and the FSM goes to R_DATA.
  - R_DATA: rvalid=1, rdata held stable until rready, then back to R_IDLE.
  - Read latency = 1 cycle after AR handshake.
- Done handling:
  - i_done pulse: ap_done=1 (sticky), ap_start=0, ap_idle=1.
  - ap_done clears on the AR handshake of 0x10.
  - If i_done coincides with that AR handshake, the set wins: rdata shows the old value and ap_done remains 1 for the next read.
  - i_done while not busy is still recorded (sets ap_done).
- Read and write FSMs are independent and may be active simultaneously.
- o_byte_len/o_src_addr/o_dst_addr are direct register outputs, stable for the whole transfer.

Test Plan:
1. Reset -> read 0x10 returns 0x4 (idle only); reads of 0x14/0x18/0x1C return 0; bresp/rresp are 0.
2. Write 0x14=0x1000, 0x18=0x1000_0000, 0x1C=0x2000_0000 -> o_byte_len/o_src_addr/o_dst_addr show those values; read-back matches; bvalid is asserted 2 cycles after the AW handshake.
3. Write 0x10=1 -> o_start high for exactly 1 cycle; then read 0x10 = 0x1; write 0x14=0x20 while busy -> o_byte_len stays 0x1000.
4. Pulse i_done -> read 0x10 = 0x6 (masked with 0xFFFF_FFF2 gives 0x2); second read = 0x4.
5. i_done in the same cycle as the AR handshake of 0x10 -> first read shows bit1=0; next read shows 0x6.
6. wstrb=4'b0011 write 0xAAAA_BBBB to 0x18 (old 0x1000_0000) -> 0x1000_BBBB; read of 0x3C returns 0; ap_rst asserted in W_DATA -> awready=1, bvalid=0 next cycle.
